regfile_wb_arbiter: RTL and testbench

//  Owns the single regfile write port: round-robin arbitrates ALU and LSU

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_wb_rr_arb.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizes and the round-robin source encoding for the regfile write-back path.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_SIZE = 5;
    localparam int REG_DATA_SIZE = 32;
    localparam int REG_SIZE      = 32;

    // rr_ptr encoding: which requester holds priority when both ask at once
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    function automatic wb_src_e other_src(input wb_src_e src);
        return (src == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_arb.sv
// Two-input round-robin arbiter: an uncontested requester is always ready,
// and a contested cycle goes to whichever side rr_ptr names.
module wb_rr_arb
    import regfile_wb_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    a_valid,
    input  logic    b_valid,
    output logic    a_ready,
    output logic    b_ready,
    output logic    grant_valid,
    output wb_src_e grant_src
);

    wb_src_e rr_ptr;
    logic    a_xfer;
    logic    b_xfer;

    always_comb begin
        a_ready     = !b_valid || (rr_ptr == WB_SRC_ALU);
        b_ready     = !a_valid || (rr_ptr == WB_SRC_LSU);
        a_xfer      = a_valid && a_ready;
        b_xfer      = b_valid && b_ready;
        grant_valid = a_xfer || b_xfer;
        grant_src   = b_xfer ? WB_SRC_LSU : WB_SRC_ALU;
    end

    // Any transfer hands priority to the other side, even when uncontested
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= WB_SRC_ALU;
        end else if (grant_valid) begin
            rr_ptr <= other_src(grant_src);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port owner: arbitrates ALU/LSU write-back into one registered
// write and keeps the per-GPR busy scoreboard used by decode for hazard stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_SIZE,
    parameter int DATA_W = REG_DATA_SIZE,
    parameter int NREG   = REG_SIZE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] chk_addr_1,
    output logic              busy_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    output logic              busy_2,
    input  logic              flush
);

    logic              grant_valid;
    wb_src_e           grant_src;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;

    wb_rr_arb u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid     (a_valid),
        .b_valid     (b_valid),
        .a_ready     (a_ready),
        .b_ready     (b_ready),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    always_comb begin
        sel_addr = (grant_src == WB_SRC_LSU) ? b_addr : a_addr;
        sel_data = (grant_src == WB_SRC_LSU) ? b_data : a_data;
    end

    // Writes to x0 are accepted from the requester but never reach the regfile
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (grant_valid && (sel_addr != '0)) begin
            wr_enable <= 1'b1;
            wr_addr   <= sel_addr;
            wr_data   <= sel_data;
        end else begin
            wr_enable <= 1'b0;
        end
    end

    always_comb begin
        issue_ready = !busy[issue_addr] || (issue_addr == '0);
        busy_1      = busy[chk_addr_1] && (chk_addr_1 != '0);
        busy_2      = busy[chk_addr_2] && (chk_addr_2 != '0);
    end

    // Later assignments win: commit clear, then issue set, then flush
    always_comb begin
        busy_next = busy;
        if (wr_enable) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_addr != '0)) begin
            busy_next[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: a reference model predicts ready/busy
// each cycle and queues expected regfile writes for an independent write monitor.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic [4:0]  chk_addr_1;
    logic        busy_1;
    logic [4:0]  chk_addr_2;
    logic        busy_2;
    logic        flush;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   vectors;
    int   miscompares;

    // Reference model state: whose turn a contested cycle is, register
    // ownership, and the write the regfile sees during the current cycle
    bit   alu_turn;
    bit   busy_m[32];
    bit   pend_valid;
    int   pend_addr;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .wr_enable   (wr_enable),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .chk_addr_1  (chk_addr_1),
        .busy_1      (busy_1),
        .chk_addr_2  (chk_addr_2),
        .busy_2      (busy_2),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] pickAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic resetModel();
        alu_turn   = 1'b1;
        pend_valid = 1'b0;
        pend_addr  = 0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    endtask

    task automatic driveIdle();
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
    endtask

    // Predicts this cycle's combinational outputs, then advances the model
    // across the coming posedge
    task automatic modelCycle();
        bit exp_a_ready, exp_b_ready, exp_issue_ready;
        bit served;
        int w_addr;
        logic [31:0] w_data;

        exp_a_ready     = !b_valid || alu_turn;
        exp_b_ready     = !a_valid || !alu_turn;
        exp_issue_ready = (issue_addr == 0) || !busy_m[issue_addr];

        checkOutput("a_ready", a_ready, exp_a_ready);
        checkOutput("b_ready", b_ready, exp_b_ready);
        checkOutput("issue_ready", issue_ready, exp_issue_ready);
        checkOutput("busy_1", busy_1, (chk_addr_1 != 0) && busy_m[chk_addr_1]);
        checkOutput("busy_2", busy_2, (chk_addr_2 != 0) && busy_m[chk_addr_2]);

        served = 1'b0;
        w_addr = 0;
        w_data = '0;
        if (a_valid && exp_a_ready) begin
            served   = 1'b1;
            w_addr   = a_addr;
            w_data   = a_data;
            alu_turn = 1'b0;
        end else if (b_valid && exp_b_ready) begin
            served   = 1'b1;
            w_addr   = b_addr;
            w_data   = b_data;
            alu_turn = 1'b1;
        end
        if (served && w_addr != 0) exp_q.push_back('{addr: 5'(w_addr), data: w_data});

        if (pend_valid) busy_m[pend_addr] = 1'b0;
        if (issue_valid && exp_issue_ready && issue_addr != 0) busy_m[issue_addr] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;

        pend_valid = served && (w_addr != 0);
        pend_addr  = w_addr;
    endtask

    task automatic applyStimulus(input bit force_alu);
        @(negedge clk);
        if (force_alu) begin
            a_valid     = 1'b1;
            a_addr      = 5'd5;
            a_data      = 32'h1234;
            b_valid     = 1'b0;
            issue_valid = 1'b0;
            flush       = 1'b0;
        end else begin
            a_valid     = ($urandom_range(0, 99) < 60);
            a_addr      = pickAddr();
            a_data      = $urandom();
            b_valid     = ($urandom_range(0, 99) < 50);
            b_addr      = pickAddr();
            b_data      = $urandom();
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_addr  = pickAddr();
            flush       = ($urandom_range(0, 15) == 0);
        end
        chk_addr_1 = pickAddr();
        chk_addr_2 = pickAddr();
        #1;
        modelCycle();
    endtask

    // Write monitor: every regfile write must match the oldest accepted request
    initial begin
        wr_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && wr_enable) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write_addr", {27'd0, wr_addr}, 32'hffff_ffff);
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput("wr_addr", {27'd0, wr_addr}, {27'd0, exp.addr});
                    checkOutput("wr_data", wr_data, exp.data);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetModel();
        reset_n     = 1'b0;
        a_valid     = 1'b1;
        b_valid     = 1'b1;
        a_addr      = 5'd3;
        b_addr      = 5'd4;
        a_data      = '0;
        b_data      = '0;
        issue_valid = 1'b0;
        issue_addr  = 5'd7;
        chk_addr_1  = 5'd7;
        chk_addr_2  = 5'd0;
        flush       = 1'b0;
        #12;
        checkOutput("reset_wr_enable", wr_enable, 0);
        checkOutput("reset_wr_addr", {27'd0, wr_addr}, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_a_ready", a_ready, 1);
        checkOutput("reset_b_ready", b_ready, 0);
        checkOutput("reset_busy_1", busy_1, 0);

        @(negedge clk);
        driveIdle();
        reset_n = 1'b1;

        for (int n = 0; n < 800; n++) applyStimulus(1'b0);

        // Guarantee a live write, then pull reset asynchronously under it
        applyStimulus(1'b1);
        @(posedge clk);
        #2;
        driveIdle();
        checkOutput("wr_enable_before_reset", wr_enable, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("wr_enable_async_reset", wr_enable, 0);
        for (int i = 0; i < 32; i++) begin
            chk_addr_1 = 5'(i);
            #1;
            checkOutput("busy_after_reset", busy_1, 0);
        end
        resetModel();
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 400; n++) applyStimulus(1'b0);

        @(negedge clk);
        driveIdle();
        repeat (3) @(negedge clk);
        checkOutput("write_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
